// File: rtl/rs_station_param.sv
// Reservation station: DEPTH entries, CDB snooping wakeup, oldest-ready select into a valid/ready output register.
// Optional RS_ISSUE_BYPASS_EN: incoming pending operands also capture same-cycle CDB broadcasts.
module rs_station_param #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 4,
    parameter int OP_W  = 6,
    parameter int NCDB  = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OP_W-1:0]           in_op,
    input  logic [TAG_W-1:0]          in_tag,
    input  logic [31:0]               in_v1,
    input  logic [31:0]               in_v2,
    input  logic [TAG_W-1:0]          in_q1,
    input  logic [TAG_W-1:0]          in_q2,
    input  logic                      in_r1,
    input  logic                      in_r2,
    input  logic [31:0]               in_imm,
    input  logic [31:0]               in_pc,
    input  logic [NCDB-1:0]           cdb_valid,
    input  logic [NCDB*TAG_W-1:0]     cdb_tag,
    input  logic [NCDB*32-1:0]        cdb_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OP_W-1:0]           out_op,
    output logic [TAG_W-1:0]          out_tag,
    output logic [31:0]               out_v1,
    output logic [31:0]               out_v2,
    output logic [31:0]               out_imm,
    output logic [31:0]               out_pc,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DEPTH-1:0] valid_q, r1_q, r2_q;
    logic [OP_W-1:0]  op_q  [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [TAG_W-1:0] q1_q  [DEPTH];
    logic [TAG_W-1:0] q2_q  [DEPTH];
    logic [31:0]      v1_q  [DEPTH];
    logic [31:0]      v2_q  [DEPTH];
    logic [31:0]      imm_q [DEPTH];
    logic [31:0]      pc_q  [DEPTH];
    // older_q[j][i] set means entry j was allocated before entry i
    logic [DEPTH-1:0] older_q [DEPTH];

    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q;
    logic             out_valid_q;
    logic [OP_W-1:0]  out_op_q;
    logic [TAG_W-1:0] out_tag_q;
    logic [31:0]      out_v1_q, out_v2_q, out_imm_q, out_pc_q;

    logic [DEPTH-1:0] wk1_hit, wk2_hit;
    logic [31:0]      wk1_val [DEPTH];
    logic [31:0]      wk2_val [DEPTH];
    logic             byp1_hit, byp2_hit;
    logic [31:0]      byp1_val, byp2_val;
    logic             new_r1, new_r2;
    logic [31:0]      new_v1, new_v2;

    logic             alloc_hit, do_alloc, sel_hit, issue;
    logic [IDX_W-1:0] alloc_idx, sel_idx;
    logic [DEPTH-1:0] ready_vec, blocked;

    // Descending port scan so the lowest matching port overrides the rest
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wk1_hit[i] = 1'b0;
            wk2_hit[i] = 1'b0;
            wk1_val[i] = '0;
            wk2_val[i] = '0;
            for (int k = NCDB - 1; k >= 0; k--) begin
                if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == q1_q[i]) begin
                    wk1_hit[i] = 1'b1;
                    wk1_val[i] = cdb_data[k*32 +: 32];
                end
                if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == q2_q[i]) begin
                    wk2_hit[i] = 1'b1;
                    wk2_val[i] = cdb_data[k*32 +: 32];
                end
            end
        end
    end

`ifdef RS_ISSUE_BYPASS_EN
    always_comb begin
        byp1_hit = 1'b0;
        byp2_hit = 1'b0;
        byp1_val = '0;
        byp2_val = '0;
        for (int k = NCDB - 1; k >= 0; k--) begin
            if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == in_q1) begin
                byp1_hit = 1'b1;
                byp1_val = cdb_data[k*32 +: 32];
            end
            if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == in_q2) begin
                byp2_hit = 1'b1;
                byp2_val = cdb_data[k*32 +: 32];
            end
        end
    end
`else
    assign byp1_hit = 1'b0;
    assign byp2_hit = 1'b0;
    assign byp1_val = '0;
    assign byp2_val = '0;
`endif

    assign new_r1 = in_r1 | byp1_hit;
    assign new_r2 = in_r2 | byp2_hit;
    assign new_v1 = (!in_r1 && byp1_hit) ? byp1_val : in_v1;
    assign new_v2 = (!in_r2 && byp2_hit) ? byp2_val : in_v2;

    always_comb begin
        alloc_hit = 1'b0;
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                alloc_hit = 1'b1;
                alloc_idx = IDX_W'(i);
            end
        end
        ready_vec = valid_q & r1_q & r2_q;
        blocked   = '0;
        sel_hit   = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && ready_vec[j] && older_q[j][i]) blocked[i] = 1'b1;
            end
            if (ready_vec[i] && !blocked[i]) begin
                sel_hit = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
    end

    assign do_alloc = in_valid && !full_q && alloc_hit;
    assign issue    = (!out_valid_q || out_ready) && sel_hit;
    assign count_d  = count_q + CNT_W'(do_alloc) - CNT_W'(issue);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_op_q    <= '0;
            out_tag_q   <= '0;
            out_v1_q    <= '0;
            out_v2_q    <= '0;
            out_imm_q   <= '0;
            out_pc_q    <= '0;
        end else if (rdy) begin
            if (clear) begin
                valid_q     <= '0;
                count_q     <= '0;
                full_q      <= 1'b0;
                out_valid_q <= 1'b0;
                out_op_q    <= '0;
                out_tag_q   <= '0;
                out_v1_q    <= '0;
                out_v2_q    <= '0;
                out_imm_q   <= '0;
                out_pc_q    <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (valid_q[i] && !r1_q[i] && wk1_hit[i]) begin
                        r1_q[i] <= 1'b1;
                        v1_q[i] <= wk1_val[i];
                    end
                    if (valid_q[i] && !r2_q[i] && wk2_hit[i]) begin
                        r2_q[i] <= 1'b1;
                        v2_q[i] <= wk2_val[i];
                    end
                end
                if (issue) begin
                    valid_q[sel_idx] <= 1'b0;
                    out_valid_q      <= 1'b1;
                    out_op_q         <= op_q[sel_idx];
                    out_tag_q        <= tag_q[sel_idx];
                    out_v1_q         <= v1_q[sel_idx];
                    out_v2_q         <= v2_q[sel_idx];
                    out_imm_q        <= imm_q[sel_idx];
                    out_pc_q         <= pc_q[sel_idx];
                end else if (out_ready) begin
                    out_valid_q <= 1'b0;
                end
                if (do_alloc) begin
                    valid_q[alloc_idx] <= 1'b1;
                    op_q[alloc_idx]    <= in_op;
                    tag_q[alloc_idx]   <= in_tag;
                    q1_q[alloc_idx]    <= in_q1;
                    q2_q[alloc_idx]    <= in_q2;
                    r1_q[alloc_idx]    <= new_r1;
                    r2_q[alloc_idx]    <= new_r2;
                    v1_q[alloc_idx]    <= new_v1;
                    v2_q[alloc_idx]    <= new_v2;
                    imm_q[alloc_idx]   <= in_imm;
                    pc_q[alloc_idx]    <= in_pc;
                    for (int j = 0; j < DEPTH; j++) older_q[j][alloc_idx] <= 1'b1;
                    older_q[alloc_idx] <= '0;
                end
                count_q <= count_d;
                full_q  <= (count_d == FULL_CNT);
            end
        end
    end

    assign in_ready  = !full_q;
    assign count     = count_q;
    assign out_valid = out_valid_q;
    assign out_op    = out_op_q;
    assign out_tag   = out_tag_q;
    assign out_v1    = out_v1_q;
    assign out_v2    = out_v2_q;
    assign out_imm   = out_imm_q;
    assign out_pc    = out_pc_q;
endmodule

// File: tb/tb_rs_station_param.sv
// Bench for rs_station_param: age-ordered queue reference model, expected-output scoreboard, directed + random stimulus.
module tb_rs_station_param;
    localparam int DEPTH = 16;
    localparam int TAG_W = 4;
    localparam int OP_W  = 6;
    localparam int NCDB  = 3;
    localparam int W     = OP_W + TAG_W + 128;

    logic clk = 1'b0;
    logic rst, rdy, clear, in_valid, in_ready, in_r1, in_r2, out_valid, out_ready;
    logic [OP_W-1:0]  in_op, out_op;
    logic [TAG_W-1:0] in_tag, in_q1, in_q2, out_tag;
    logic [31:0] in_v1, in_v2, in_imm, in_pc, out_v1, out_v2, out_imm, out_pc;
    logic [NCDB-1:0]       cdb_valid;
    logic [NCDB*TAG_W-1:0] cdb_tag;
    logic [NCDB*32-1:0]    cdb_data;
    logic [$clog2(DEPTH):0] count;

    always #5 clk = ~clk;

    rs_station_param #(.DEPTH(DEPTH), .TAG_W(TAG_W), .OP_W(OP_W), .NCDB(NCDB)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_tag(in_tag),
        .in_v1(in_v1), .in_v2(in_v2), .in_q1(in_q1), .in_q2(in_q2),
        .in_r1(in_r1), .in_r2(in_r2), .in_imm(in_imm), .in_pc(in_pc),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_tag(out_tag),
        .out_v1(out_v1), .out_v2(out_v2), .out_imm(out_imm), .out_pc(out_pc),
        .count(count)
    );

    typedef struct {
        logic [OP_W-1:0]  op;
        logic [TAG_W-1:0] tag;
        logic [31:0]      v1, v2, imm, pc;
        logic [TAG_W-1:0] q1, q2;
        logic             r1, r2;
    } ent_t;

    ent_t           mq[$];
    logic [W-1:0]   exp_q[$];
    int             m_count;
    logic           m_out_valid;
    logic [W-1:0]   m_out;
    int             tests = 0;
    int             failures = 0;
    logic           mon_en = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [32:0] cdb_find(input logic [TAG_W-1:0] t);
        logic [32:0] r;
        r = '0;
        for (int k = 0; k < NCDB; k++)
            if (!r[32] && cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == t)
                r = {1'b1, cdb_data[k*32 +: 32]};
        return r;
    endfunction

    function automatic logic [W-1:0] pack_ent(input ent_t e);
        return {e.op, e.tag, e.v1, e.v2, e.imm, e.pc};
    endfunction

    // Reference model: queue kept oldest-first; issue takes the first fully-ready entry
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            exp_q.delete();
            m_count = 0;
            m_out_valid = 1'b0;
            m_out = '0;
        end else if (rdy) begin
            if (clear) begin
                mq.delete();
                exp_q.delete();
                m_count = 0;
                m_out_valid = 1'b0;
                m_out = '0;
            end else begin
                logic accept, found;
                int sel;
                ent_t e;
                logic [32:0] h;
                accept = in_valid && (m_count != DEPTH);
                found = 1'b0;
                sel = 0;
                for (int i = 0; i < mq.size(); i++)
                    if (!found && mq[i].r1 && mq[i].r2) begin
                        found = 1'b1;
                        sel = i;
                    end
                if ((!m_out_valid || out_ready) && found) begin
                    m_out = pack_ent(mq[sel]);
                    m_out_valid = 1'b1;
                    exp_q.push_back(m_out);
                    mq.delete(sel);
                end else if (out_ready) begin
                    m_out_valid = 1'b0;
                end
                for (int i = 0; i < mq.size(); i++) begin
                    e = mq[i];
                    if (!e.r1) begin
                        h = cdb_find(e.q1);
                        if (h[32]) begin e.r1 = 1'b1; e.v1 = h[31:0]; end
                    end
                    if (!e.r2) begin
                        h = cdb_find(e.q2);
                        if (h[32]) begin e.r2 = 1'b1; e.v2 = h[31:0]; end
                    end
                    mq[i] = e;
                end
                if (accept) begin
                    e.op = in_op; e.tag = in_tag; e.v1 = in_v1; e.v2 = in_v2;
                    e.imm = in_imm; e.pc = in_pc; e.q1 = in_q1; e.q2 = in_q2;
                    e.r1 = in_r1; e.r2 = in_r2;
`ifdef RS_ISSUE_BYPASS_EN
                    if (!e.r1) begin
                        h = cdb_find(e.q1);
                        if (h[32]) begin e.r1 = 1'b1; e.v1 = h[31:0]; end
                    end
                    if (!e.r2) begin
                        h = cdb_find(e.q2);
                        if (h[32]) begin e.r2 = 1'b1; e.v2 = h[31:0]; end
                    end
`endif
                    mq.push_back(e);
                end
                m_count = mq.size();
            end
        end
    end

    // Monitor: state checks every cycle, scoreboard pop on each accepted output
    always @(negedge clk) begin
        if (mon_en) begin
            check("count", W'(count), W'(m_count));
            check("in_ready", W'(in_ready), W'(m_count != DEPTH));
            check("out_valid", W'(out_valid), W'(m_out_valid));
            check("out_regs", {out_op, out_tag, out_v1, out_v2, out_imm, out_pc}, m_out);
            if (out_valid && out_ready && rdy && !clear && !rst) begin
                if (exp_q.size() == 0) begin
                    check("sb_nonempty", W'(0), W'(1));
                end else begin
                    check("sb_issue", {out_op, out_tag, out_v1, out_v2, out_imm, out_pc}, exp_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        cdb_valid = '0;
        cdb_tag = '0;
        cdb_data = '0;
    endtask

    task automatic dispatch(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] tag,
                            input logic [31:0] v1, input logic [31:0] v2,
                            input logic [TAG_W-1:0] q1, input logic [TAG_W-1:0] q2,
                            input logic r1, input logic r2);
        in_valid = 1'b1; in_op = op; in_tag = tag; in_v1 = v1; in_v2 = v2;
        in_q1 = q1; in_q2 = q2; in_r1 = r1; in_r2 = r2;
        in_imm = 32'h1000 + 32'(tag); in_pc = 32'h8000 + 32'(tag);
    endtask

    task automatic broadcast(input int port, input logic [TAG_W-1:0] t, input logic [31:0] d);
        cdb_valid[port] = 1'b1;
        cdb_tag[port*TAG_W +: TAG_W] = t;
        cdb_data[port*32 +: 32] = d;
    endtask

    logic [W-1:0] snap;

    initial begin
        rst = 1'b1; rdy = 1'b1; clear = 1'b0; out_ready = 1'b1;
        in_op = '0; in_tag = '0; in_v1 = '0; in_v2 = '0; in_q1 = '0; in_q2 = '0;
        in_r1 = 1'b0; in_r2 = 1'b0; in_imm = '0; in_pc = '0;
        idle();
        repeat (3) step();
        check("rst_count", W'(count), W'(0));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_in_ready", W'(in_ready), W'(1));
        rst = 1'b0;
        mon_en = 1'b1;

        // both operands ready: out_valid two edges after dispatch
        dispatch(6'h01, 4'd3, 32'd5, 32'd7, 4'd0, 4'd0, 1'b1, 1'b1);
        step(); idle();
        check("t1_lat1", W'(out_valid), W'(0));
        step();
        check("t1_valid", W'(out_valid), W'(1));
        check("t1_v1", W'(out_v1), W'(5));
        check("t1_v2", W'(out_v2), W'(7));
        check("t1_tag", W'(out_tag), W'(3));
        step();

        // shared producer wakes two entries; lowest cdb port wins
        dispatch(6'h02, 4'd1, 32'd0, 32'd11, 4'd9, 4'd0, 1'b0, 1'b1);
        step();
        dispatch(6'h02, 4'd2, 32'd0, 32'd12, 4'd9, 4'd0, 1'b0, 1'b1);
        step(); idle();
        broadcast(0, 4'd9, 32'h55);
        broadcast(1, 4'd9, 32'h66);
        step(); idle();
        check("t2_nowake_yet", W'(out_valid), W'(0));
        step();
        check("t2_first_tag", W'(out_tag), W'(1));
        check("t2_first_v1", W'(out_v1), W'(32'h55));
        step();
        check("t2_second_tag", W'(out_tag), W'(2));
        check("t2_second_v1", W'(out_v1), W'(32'h55));
        step();

        // fill to capacity with stalled FU, then stall with valid output
        out_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            dispatch(6'h03, 4'(i), 32'd0, 32'(i), 4'd15, 4'd0, 1'b0, 1'b1);
            step();
        end
        idle();
        check("t3_count_full", W'(count), W'(DEPTH));
        check("t3_in_ready", W'(in_ready), W'(0));
        broadcast(2, 4'd15, 32'hF0);
        step(); idle();
        step();
        snap = {out_op, out_tag, out_v1, out_v2, out_imm, out_pc};
        check("t4_oldest", W'(out_tag), W'(0));
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_stall_valid", W'(out_valid), W'(1));
            check("t4_stall_stable", {out_op, out_tag, out_v1, out_v2, out_imm, out_pc}, snap);
        end
        out_ready = 1'b1;
        step();
        check("t4_b2b_valid", W'(out_valid), W'(1));
        check("t4_b2b_tag", W'(out_tag), W'(1));
        repeat (DEPTH + 2) step();

        // flush beats issue and dispatch
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dispatch(6'h04, 4'(4 + i), 32'(i), 32'(i), 4'd0, 4'd0, 1'b1, 1'b1);
            step();
        end
        check("t5_pre_count", W'(count), W'(4));
        check("t5_pre_valid", W'(out_valid), W'(1));
        out_ready = 1'b1;
        clear = 1'b1;
        dispatch(6'h05, 4'd9, 32'd1, 32'd1, 4'd0, 4'd0, 1'b1, 1'b1);
        step(); idle();
        clear = 1'b0;
        check("t5_count", W'(count), W'(0));
        check("t5_valid", W'(out_valid), W'(0));
        check("t5_tag_zero", W'(out_tag), W'(0));
        step();
        check("t5_no_store", W'(count), W'(0));

        // pending operand produced in the dispatch cycle
        dispatch(6'h06, 4'd6, 32'd0, 32'd1, 4'd5, 4'd0, 1'b0, 1'b1);
        broadcast(0, 4'd5, 32'hAB);
        step(); idle();
        step();
`ifdef RS_ISSUE_BYPASS_EN
        check("t6_byp_valid", W'(out_valid), W'(1));
        check("t6_byp_v1", W'(out_v1), W'(32'hAB));
`else
        check("t6_stall_valid", W'(out_valid), W'(0));
        repeat (4) step();
        check("t6_stall_valid_late", W'(out_valid), W'(0));
        check("t6_stall_count", W'(count), W'(1));
        broadcast(0, 4'd5, 32'hAB);
        step(); idle();
        step();
        check("t6_late_v1", W'(out_v1), W'(32'hAB));
`endif
        repeat (3) step();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rdy = ($urandom_range(0, 15) != 0);
            clear = ($urandom_range(0, 149) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) < 6)
                dispatch(6'($urandom), 4'($urandom), $urandom, $urandom, 4'($urandom), 4'($urandom),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                in_valid = 1'b0;
            for (int k = 0; k < NCDB; k++) begin
                cdb_valid[k] = ($urandom_range(0, 2) == 0);
                cdb_tag[k*TAG_W +: TAG_W] = 4'($urandom);
                cdb_data[k*32 +: 32] = $urandom;
            end
            step();
        end
        idle();
        rdy = 1'b1; clear = 1'b0; out_ready = 1'b1;
        repeat (5) step();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
